// File: rtl/latch_mem_sweep_reader.sv
// latch_mem_sweep_reader
//   Read-side initiator for the dual-port latch memory. Walks a contiguous run of
//   entries (wrapping at NUM_WORDS-1 -> 0) through one read port and streams each
//   entry out over a valid/ready interface, one entry per two cycles.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start_i         sweep request pulse (looked at in IDLE only)
//   start_idx_i     first entry index
//   count_i         number of entries, 0..NUM_WORDS
//   abort_i         cancel the sweep in progress
//   busy_o          high while not IDLE
//   done_o          1-cycle pulse: sweep completed (or zero-length request)
//   err_o           1-cycle pulse: request rejected
//   raddr_o         registered read address to the memory
//   rdata_i         read data, combinational from raddr_o
//   out_valid_o     entry available
//   out_ready_i     consumer accepts the entry
//   out_data_o      registered entry data
//   out_idx_o       index of out_data_o
//   out_parity_o    ^out_data_o (only with LATCH_MEM_SWEEP_PARITY_EN defined)
//
// Build option: LATCH_MEM_SWEEP_PARITY_EN adds out_parity_o.
module latch_mem_sweep_reader #(
    parameter int NUM_WORDS  = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] start_idx_i,
    input  logic [ADDR_WIDTH:0]   count_i,
    input  logic                  abort_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [ADDR_WIDTH-1:0] raddr_o,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
`ifdef LATCH_MEM_SWEEP_PARITY_EN
    output logic [ADDR_WIDTH-1:0] out_idx_o,
    output logic                  out_parity_o
`else
    output logic [ADDR_WIDTH-1:0] out_idx_o
`endif
);

    localparam logic [ADDR_WIDTH:0]   LP_NW   = (ADDR_WIDTH+1)'(NUM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] LP_LAST = ADDR_WIDTH'(NUM_WORDS-1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_OUT} state_t;

    state_t                r_state, w_nxt;
    logic [ADDR_WIDTH-1:0] r_raddr;   // doubles as the sweep address
    logic [ADDR_WIDTH:0]   r_rem;
    logic                  r_done, r_err, r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic                  w_bad, w_zero, w_hs, w_last;

    always_comb begin
        w_bad  = ({1'b0, start_idx_i} >= LP_NW) || (count_i > LP_NW);
        w_zero = (count_i == '0);
        // abort outranks the handshake: an entry accepted in the abort cycle is dropped
        w_hs   = (r_state == S_OUT) && r_valid && out_ready_i && !abort_i;
        w_last = (r_rem == (ADDR_WIDTH+1)'(1));
        w_nxt  = r_state;
        case (r_state)
            S_IDLE:  if (start_i && !w_bad && !w_zero) w_nxt = S_FETCH;
            S_FETCH: w_nxt = abort_i ? S_IDLE : S_OUT;
            S_OUT: begin
                if (abort_i)   w_nxt = S_IDLE;
                else if (w_hs) w_nxt = w_last ? S_IDLE : S_FETCH;
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_raddr <= '0;
            r_rem   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_idx   <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        if (w_bad)       r_err  <= 1'b1;
                        else if (w_zero) r_done <= 1'b1;
                        else begin
                            r_raddr <= start_idx_i;
                            r_rem   <= count_i;
                        end
                    end
                end
                S_FETCH: begin
                    if (!abort_i) begin
                        r_data  <= rdata_i;
                        r_idx   <= r_raddr;
                        r_valid <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (abort_i) begin
                        r_valid <= 1'b0;
                    end else if (w_hs) begin
                        r_valid <= 1'b0;
                        r_rem   <= r_rem - 1'b1;
                        if (w_last) r_done  <= 1'b1;
                        else        r_raddr <= (r_raddr == LP_LAST) ? '0 : r_raddr + 1'b1;
                    end
                end
                default: r_valid <= 1'b0;
            endcase
        end
    end

`ifdef LATCH_MEM_SWEEP_PARITY_EN
    logic r_par;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                r_par <= 1'b0;
        else if (r_state == S_FETCH && !abort_i)   r_par <= ^rdata_i;
    end
    assign out_parity_o = r_par;
`endif

    assign busy_o      = (r_state != S_IDLE);
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign raddr_o     = r_raddr;
    assign out_valid_o = r_valid;
    assign out_data_o  = r_data;
    assign out_idx_o   = r_idx;

endmodule

// File: tb/tb_latch_mem_sweep_reader.sv
// Bench for latch_mem_sweep_reader: a memory model drives rdata, expected entries are
// queued when a sweep is requested and compared as the DUT presents them.
// A second instance with NUM_WORDS=20 exercises the out-of-range start index.
module tb_latch_mem_sweep_reader;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0, start2 = 1'b0, abort = 1'b0, ready = 1'b1;
    logic [4:0]   start_idx = '0;
    logic [5:0]   count = '0;
    logic         busy, done, err, out_valid;
    logic [4:0]   raddr, out_idx;
    logic [127:0] rdata, out_data;
    logic         busy2, done2, err2, valid2;
    logic [4:0]   raddr2, idx2;
    logic [127:0] data2;
`ifdef LATCH_MEM_SWEEP_PARITY_EN
    logic         par, par2;
`endif

    logic [127:0] mem [32];
    logic [4:0]   q_idx [$];
    logic [127:0] q_dat [$];
    int           n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;
    assign rdata = mem[raddr];

    latch_mem_sweep_reader #(.NUM_WORDS(32), .ADDR_WIDTH(5), .DATA_WIDTH(128)) u_dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .start_idx_i(start_idx), .count_i(count),
        .abort_i(abort), .busy_o(busy), .done_o(done), .err_o(err), .raddr_o(raddr),
        .rdata_i(rdata), .out_valid_o(out_valid), .out_ready_i(ready), .out_data_o(out_data),
`ifdef LATCH_MEM_SWEEP_PARITY_EN
        .out_parity_o(par),
`endif
        .out_idx_o(out_idx));

    latch_mem_sweep_reader #(.NUM_WORDS(20), .ADDR_WIDTH(5), .DATA_WIDTH(128)) u_dut20 (
        .clk(clk), .rst_n(rst_n), .start_i(start2), .start_idx_i(start_idx), .count_i(count),
        .abort_i(1'b0), .busy_o(busy2), .done_o(done2), .err_o(err2), .raddr_o(raddr2),
        .rdata_i(128'h0), .out_valid_o(valid2), .out_ready_i(1'b1), .out_data_o(data2),
`ifdef LATCH_MEM_SWEEP_PARITY_EN
        .out_parity_o(par2),
`endif
        .out_idx_o(idx2));

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // bp: toggle ready every cycle; abort_at: abort when the Nth entry appears (0 = never)
    task automatic sweep(input logic [4:0] idx, input logic [5:0] cnt, input bit bp, input int abort_at);
        bit fin = 0, just_final = 0, prev_v = 0;
        int nval = 0;
        for (int k = 0; k < int'(cnt); k++) begin
            logic [4:0] a;
            a = 5'((int'(idx) + k) % 32);
            q_idx.push_back(a);
            q_dat.push_back(mem[a]);
        end
        @(negedge clk);
        start = 1'b1; start_idx = idx; count = cnt;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 1) chk("lat_fetch", {127'b0, out_valid}, 128'd0);
            if (cyc == 2) chk("lat_valid", {127'b0, out_valid}, 128'd1);
            chk("done", {127'b0, done}, {127'b0, just_final});
            if (just_final) begin
                chk("busy_end", {127'b0, busy}, 128'd0);
                fin = 1;
                break;
            end
            ready = bp ? cyc[0] : 1'b1;
            if (out_valid) begin
                if (q_idx.size() == 0) begin
                    chk("extra_entry", 128'd1, 128'd0);
                    break;
                end
                chk("idx", {123'b0, out_idx}, {123'b0, q_idx[0]});
                chk("data", out_data, q_dat[0]);
`ifdef LATCH_MEM_SWEEP_PARITY_EN
                chk("parity", {127'b0, par}, {127'b0, ^q_dat[0]});
`endif
                if (!prev_v) begin
                    nval++;
                    if (nval == abort_at) begin
                        abort = 1'b1;
                        @(negedge clk);
                        abort = 1'b0;
                        chk("abort_valid", {127'b0, out_valid}, 128'd0);
                        chk("abort_busy", {127'b0, busy}, 128'd0);
                        chk("abort_done", {127'b0, done}, 128'd0);
                        q_idx.delete(); q_dat.delete();
                        fin = 1;
                        break;
                    end
                end
                if (ready) begin
                    void'(q_idx.pop_front());
                    void'(q_dat.pop_front());
                    if (q_idx.size() == 0) just_final = 1;
                end
            end
            prev_v = out_valid;
        end
        if (!fin) chk("timeout", 128'd1, 128'd0);
        ready = 1'b1;
    endtask

    // one rejected/empty request: check the pulse, then that it lasts one cycle
    task automatic bad_req(input string tag, input bit on20, input logic [4:0] idx, input logic [5:0] cnt,
                           input bit exp_err, input bit exp_done);
        @(negedge clk);
        start_idx = idx; count = cnt;
        if (on20) start2 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start = 1'b0; start2 = 1'b0;
        chk({tag, "_err"},  {127'b0, on20 ? err2 : err},   {127'b0, exp_err});
        chk({tag, "_done"}, {127'b0, on20 ? done2 : done}, {127'b0, exp_done});
        chk({tag, "_busy"}, {127'b0, on20 ? busy2 : busy}, 128'd0);
        @(negedge clk);
        chk({tag, "_pulse"}, {126'b0, err, done}, 128'd0);
        chk({tag, "_valid"}, {127'b0, out_valid}, 128'd0);
    endtask

    initial begin
        mem[0] = '0;
        for (int i = 1; i < 32; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        #1;
        chk("rst_busy",  {127'b0, busy}, 128'd0);
        chk("rst_outs",  {123'b0, done, err, out_valid, 2'b0}, 128'd0);
        chk("rst_raddr", {123'b0, raddr}, 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // mid-OUT asynchronous reset
        @(negedge clk);
        start = 1'b1; start_idx = 5'd10; count = 6'd3;
        @(negedge clk); start = 1'b0; ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", {127'b0, out_valid}, 128'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {127'b0, out_valid}, 128'd0);
        chk("arst_busy",  {127'b0, busy}, 128'd0);
        chk("arst_data",  out_data, 128'd0);
        chk("arst_idx",   {123'b0, out_idx}, 128'd0);
        chk("arst_raddr", {123'b0, raddr}, 128'd0);
        @(negedge clk); rst_n = 1'b1; ready = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {126'b0, busy, out_valid}, 128'd0);

        sweep(5'd3, 6'd4, 1'b0, 0);        // basic run
        sweep(5'd30, 6'd4, 1'b1, 0);       // wrap + backpressure, entry 0 is zero
        bad_req("cnt33", 1'b0, 5'd2, 6'd33, 1'b1, 1'b0);
        bad_req("cnt0",  1'b0, 5'd2, 6'd0,  1'b0, 1'b1);
        bad_req("idx20", 1'b1, 5'd20, 6'd1, 1'b1, 1'b0);
        sweep(5'd8, 6'd8, 1'b0, 3);        // abort at third entry
        sweep(5'd12, 6'd3, 1'b1, 0);       // clean run after abort
        sweep(5'd0, 6'd32, 1'b0, 0);       // full memory

        // start while busy is ignored
        @(negedge clk);
        start = 1'b1; start_idx = 5'd1; count = 6'd2;
        @(negedge clk); start_idx = 5'd31; count = 6'd33;
        @(negedge clk); start = 1'b0;
        chk("busy_start_err", {127'b0, err}, 128'd0);
        chk("busy_start_idx", {123'b0, out_idx}, 128'd1);
        repeat (6) @(negedge clk);
        chk("busy_start_idle", {127'b0, busy}, 128'd0);

        mem[5] = 128'h1;
        mem[6] = 128'h3;
`ifdef LATCH_MEM_SWEEP_PARITY_EN
        @(negedge clk);
        start = 1'b1; start_idx = 5'd5; count = 6'd2;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        chk("par_01", {127'b0, par}, 128'd1);
        repeat (2) @(negedge clk);
        chk("par_03", {127'b0, par}, 128'd0);
        repeat (3) @(negedge clk);
`endif
        sweep(5'd4, 6'd3, 1'b1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
